// File: rtl/qcs_clk_div_gen.sv
// qcs_clk_div_gen: programmable glitch-free clock divider with run/stop control,
// deferred divisor updates at period boundaries, edge strobes and a period counter.
`default_nettype none

module qcs_clk_div_gen #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2,
  parameter int PCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              div_load,
  output logic              clk_out,
  output logic              rise_stb,
  output logic              fall_stb,
  output logic              running,
  output logic              div_busy,
  output logic [DIV_W-1:0]  cur_div,
  output logic [PCNT_W-1:0] period_cnt
);

  localparam logic [DIV_W-1:0]  ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0]  TWO     = DIV_W'(2);
  localparam logic [DIV_W-1:0]  RST_DIV = (DEF_DIV < 2) ? DIV_W'(2) : DIV_W'(DEF_DIV);
  localparam logic [PCNT_W-1:0] PONE    = PCNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pending;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] load_val;
  logic [DIV_W:0]   hi_len;
  logic             wrap;
  logic             next_hi;

  assign cnt_inc  = cnt + ONE;
  assign wrap     = (cnt == (cur_div - ONE));
  assign hi_len   = ({1'b0, cur_div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
  assign next_hi  = ({1'b0, cnt_inc} < hi_len);
  assign load_val = (div_val < TWO) ? TWO : div_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= RST_DIV;
      clk_out    <= 1'b0;
      rise_stb   <= 1'b0;
      fall_stb   <= 1'b0;
      running    <= 1'b0;
      div_busy   <= 1'b0;
      cur_div    <= RST_DIV;
      period_cnt <= '0;
    end else begin
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (div_load) cur_div <= load_val;
          if (en) begin
            state    <= RUN;
            running  <= 1'b1;
            cnt      <= '0;
            clk_out  <= 1'b1;
            rise_stb <= 1'b1;
          end
        end
        RUN, STOPPING: begin
          if (wrap) begin
            // The last count of a period is always in the low phase, so the
            // restart edge is a clean rise and the stop leaves clk_out low.
            period_cnt <= period_cnt + PONE;
            cnt        <= '0;
            if (en) begin
              state    <= RUN;
              clk_out  <= 1'b1;
              rise_stb <= 1'b1;
              if (div_busy) cur_div <= pending;
              div_busy <= div_load;
              if (div_load) pending <= load_val;
            end else begin
              state   <= IDLE;
              running <= 1'b0;
              clk_out <= 1'b0;
              if (div_load)      cur_div <= load_val;
              else if (div_busy) cur_div <= pending;
              div_busy <= 1'b0;
            end
          end else begin
            state    <= en ? RUN : STOPPING;
            cnt      <= cnt_inc;
            clk_out  <= next_hi;
            rise_stb <= next_hi & ~clk_out;
            fall_stb <= ~next_hi & clk_out;
            if (div_load) begin
              pending  <= load_val;
              div_busy <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          running  <= 1'b0;
          clk_out  <= 1'b0;
          div_busy <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qcs_clk_div_gen.sv
// tb_qcs_clk_div_gen: directed and randomized checks of qcs_clk_div_gen against
// a cycle-level behavioural model of the divider's waveform and counters.
`default_nettype none

module tb_qcs_clk_div_gen;

  localparam int DIV_W  = 8;
  localparam int PCNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [DIV_W-1:0]  div_val;
  logic              div_load;
  logic              clk_out;
  logic              rise_stb;
  logic              fall_stb;
  logic              running;
  logic              div_busy;
  logic [DIV_W-1:0]  cur_div;
  logic [PCNT_W-1:0] period_cnt;

  qcs_clk_div_gen #(.DIV_W(DIV_W), .DEF_DIV(2), .PCNT_W(PCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_val(div_val), .div_load(div_load),
    .clk_out(clk_out), .rise_stb(rise_stb), .fall_stb(fall_stb), .running(running),
    .div_busy(div_busy), .cur_div(cur_div), .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: position within the current output period and the divisor in force.
  bit m_run, m_busy, m_clk, m_rise, m_fall;
  int m_pos, m_n, m_pend, m_per;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_busy = 0; m_clk = 0; m_rise = 0; m_fall = 0;
    m_pos = 0; m_n = 2; m_pend = 2; m_per = 0;
  endtask

  task automatic model_step(input bit e, input bit l, input int v);
    int  lv;
    bit  nclk;
    lv = (v < 2) ? 2 : v;
    if (!m_run) begin
      if (l) m_n = lv;
      if (e) begin m_run = 1; m_pos = 0; end
    end else if (m_pos == m_n - 1) begin
      m_per = (m_per + 1) % (1 << PCNT_W);
      if (e) begin
        if (m_busy) m_n = m_pend;
        m_busy = l;
        if (l) m_pend = lv;
        m_pos = 0;
      end else begin
        m_run = 0;
        if (l) m_n = lv;
        else if (m_busy) m_n = m_pend;
        m_busy = 0;
      end
    end else begin
      m_pos++;
      if (l) begin m_pend = lv; m_busy = 1; end
    end
    nclk   = m_run && (m_pos < (m_n + 1) / 2);
    m_rise = nclk && !m_clk;
    m_fall = !nclk && m_clk;
    m_clk  = nclk;
  endtask

  task automatic compare_all();
    check_eq("clk_out",    clk_out,    m_clk);
    check_eq("rise_stb",   rise_stb,   m_rise);
    check_eq("fall_stb",   fall_stb,   m_fall);
    check_eq("running",    running,    m_run);
    check_eq("div_busy",   div_busy,   m_busy);
    check_eq("cur_div",    cur_div,    m_n);
    check_eq("period_cnt", period_cnt, m_per);
  endtask

  task automatic step(input bit e, input bit l, input int v);
    en = e; div_load = l; div_val = DIV_W'(v);
    model_step(e, l, v);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_cycles(input int n, input bit e);
    for (int i = 0; i < n; i++) step(e, 1'b0, 0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (m_run && guard < 600) begin
      step(1'b0, 1'b0, 0);
      guard++;
    end
    if (guard >= 600) check_eq("idle_timeout", running, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_val = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Default N=2, several periods, then stop.
    run_cycles(9, 1'b1);
    wait_idle();

    // N=5 loaded in IDLE.
    step(1'b0, 1'b1, 5);
    run_cycles(16, 1'b1);
    wait_idle();

    // N=4 running, load 7 at cnt=1.
    step(1'b0, 1'b1, 4);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 7);
    run_cycles(18, 1'b1);
    wait_idle();

    // N=6, drop en at cnt=2, then a second stop with en re-raised mid-STOPPING.
    step(1'b0, 1'b1, 6);
    run_cycles(3, 1'b1);
    wait_idle();
    run_cycles(4, 1'b0);
    run_cycles(3, 1'b1);
    run_cycles(2, 1'b0);
    run_cycles(10, 1'b1);
    wait_idle();

    // Clamp of 0 and 1; two loads in one period with last one winning.
    step(1'b0, 1'b1, 0);
    check_eq("clamp0", cur_div, 2);
    step(1'b0, 1'b1, 1);
    check_eq("clamp1", cur_div, 2);
    step(1'b0, 1'b1, 8);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 3);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 9);
    run_cycles(25, 1'b1);
    // Load coinciding with the stop wrap.
    while (m_run && m_pos != m_n - 1) step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 11);
    check_eq("stop_load", cur_div, 11);

    // Async reset in the middle of a high phase with N=8.
    step(1'b0, 1'b1, 8);
    run_cycles(2, 1'b1);
    check_eq("pre_rst_high", clk_out, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    en = 1'b0; div_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Randomized run/stop/load traffic, including period counter wrap.
    begin
      bit e;
      e = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        bit l;
        int v;
        if ($urandom_range(0, 24) == 0) e = ~e;
        l = ($urandom_range(0, 11) == 0);
        v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 14);
        step(e, l, v);
      end
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
